// File: rtl/wb_regfile_scoreboard.sv
// Writeback stage, architectural register file and per-register busy scoreboard.
// Results from MEM and EXE share one write port (MEM wins). The scoreboard
// counts issued-but-unwritten uops per destination so schedule can detect
// source-operand conflicts.
// Optional feature: define WB_BYPASS_EN to forward the accepted writeback
// into rd_data/rd_busy in the same cycle.
module wb_regfile_scoreboard #(
    parameter int NUM_REGS = 17,
    parameter int DATA_W   = 64,
    parameter int IDX_W    = 5,
    parameter int CNT_W    = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [IDX_W-1:0]  rd_idx  [3],
    output logic [DATA_W-1:0] rd_data [3],
    output logic [2:0]        rd_busy,
    input  logic              iss_valid,
    input  logic [IDX_W-1:0]  iss_dst,
    output logic              iss_ready,
    input  logic              exe_valid,
    input  logic [IDX_W-1:0]  exe_idx,
    input  logic [DATA_W-1:0] exe_data,
    output logic              exe_ready,
    input  logic              mem_valid,
    input  logic [IDX_W-1:0]  mem_idx,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    input  logic              flush
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [IDX_W:0]   NUM_R   = (IDX_W+1)'(NUM_REGS);

    logic [DATA_W-1:0] regs    [NUM_REGS];
    logic [CNT_W-1:0]  cnt     [NUM_REGS];
    logic [CNT_W-1:0]  cnt_nxt [NUM_REGS];

    logic              wb_en;
    logic              wb_hit;
    logic [IDX_W-1:0]  wb_idx;
    logic [DATA_W-1:0] wb_data;
    logic              iss_in_range;
    logic              iss_fire;
    logic [CNT_W-1:0]  iss_cnt;

    // Write-port arbitration: MEM has priority, nothing is accepted in reset.
    always_comb begin
        mem_ready = reset_n && mem_valid;
        exe_ready = reset_n && exe_valid && !mem_valid;
        wb_en     = mem_ready || exe_ready;
        wb_idx    = mem_valid ? mem_idx  : exe_idx;
        wb_data   = mem_valid ? mem_data : exe_data;
        wb_hit    = wb_en && ({1'b0, wb_idx} < NUM_R);
    end

    // Issue handshake; out-of-range destinations are accepted and ignored.
    always_comb begin
        iss_in_range = {1'b0, iss_dst} < NUM_R;
        iss_cnt      = iss_in_range ? cnt[iss_dst] : '0;
        iss_ready    = !iss_in_range || (iss_cnt != CNT_MAX);
        iss_fire     = iss_valid && iss_ready && iss_in_range;
    end

    // Next counter values: flush clears everything, otherwise +issue -write.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            logic inc;
            logic dec;
            inc = iss_fire && (iss_dst == IDX_W'(r));
            dec = wb_hit && (wb_idx == IDX_W'(r)) && ((cnt[r] != '0) || inc);
            cnt_nxt[r] = cnt[r];
            if (flush)
                cnt_nxt[r] = '0;
            else if (inc && !dec)
                cnt_nxt[r] = cnt[r] + 1'b1;
            else if (dec && !inc)
                cnt_nxt[r] = cnt[r] - 1'b1;
        end
    end

    // Scoreboard counters and register file update.
    always_ff @(posedge clk) begin
        for (int r = 0; r < NUM_REGS; r++) begin
            if (!reset_n) begin
                cnt[r]  <= '0;
                regs[r] <= '0;
            end else begin
                cnt[r] <= cnt_nxt[r];
                if (wb_hit && (wb_idx == IDX_W'(r)))
                    regs[r] <= wb_data;
            end
        end
    end

    // A result for a register with nothing outstanding means upstream lost track.
    always_ff @(posedge clk) begin
        if (reset_n && wb_hit && !flush)
            assert ((cnt[wb_idx] != '0) || (iss_fire && (iss_dst == wb_idx)));
    end

    // Source operand reads and conflict flags.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            rd_data[i] = '0;
            rd_busy[i] = 1'b0;
            if ({1'b0, rd_idx[i]} < NUM_R) begin
                rd_data[i] = regs[rd_idx[i]];
                rd_busy[i] = cnt[rd_idx[i]] != '0;
`ifdef WB_BYPASS_EN
                if (wb_hit && (wb_idx == rd_idx[i])) begin
                    rd_data[i] = wb_data;
                    if ((cnt[rd_idx[i]] == CNT_W'(1)) &&
                        !(iss_fire && (iss_dst == rd_idx[i])))
                        rd_busy[i] = 1'b0;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_wb_regfile_scoreboard.sv
// Directed bench for wb_regfile_scoreboard; expectations adapt to WB_BYPASS_EN.
module tb_wb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  rd_idx  [3];
    logic [63:0] rd_data [3];
    logic [2:0]  rd_busy;
    logic        iss_valid;
    logic [4:0]  iss_dst;
    logic        iss_ready;
    logic        exe_valid;
    logic [4:0]  exe_idx;
    logic [63:0] exe_data;
    logic        exe_ready;
    logic        mem_valid;
    logic [4:0]  mem_idx;
    logic [63:0] mem_data;
    logic        mem_ready;
    logic        flush;

    int n_vec = 0;
    int n_err = 0;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    always #5 clk = ~clk;

    wb_regfile_scoreboard dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rd_idx    (rd_idx),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .iss_valid (iss_valid),
        .iss_dst   (iss_dst),
        .iss_ready (iss_ready),
        .exe_valid (exe_valid),
        .exe_idx   (exe_idx),
        .exe_data  (exe_data),
        .exe_ready (exe_ready),
        .mem_valid (mem_valid),
        .mem_idx   (mem_idx),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .flush     (flush)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        rd_idx[0] = 5'd0; rd_idx[1] = 5'd3; rd_idx[2] = 5'd16;
        iss_valid = 1'b0; iss_dst = 5'd0;
        exe_valid = 1'b0; exe_idx = 5'd0; exe_data = '0;
        mem_valid = 1'b1; mem_idx = 5'd20; mem_data = 64'h1;
        flush     = 1'b0;

        // 1: reset
        cyc(); cyc();
        #2;
        chk("rst_mem_ready", 64'(mem_ready), 64'd0);
        mem_valid = 1'b0;
        reset_n   = 1'b1;
        cyc();
        #2;
        chk("rst_data0", rd_data[0], 64'd0);
        chk("rst_data1", rd_data[1], 64'd0);
        chk("rst_data2", rd_data[2], 64'd0);
        chk("rst_busy", 64'(rd_busy), 64'd0);
        chk("rst_iss_ready", 64'(iss_ready), 64'd1);
        chk("rst_exe_ready", 64'(exe_ready), 64'd0);

        // 2: issue r3, EXE writes it two cycles later
        iss_valid = 1'b1; iss_dst = 5'd3;
        cyc();
        iss_valid = 1'b0;
        #2;
        chk("t2_busy_a", 64'(rd_busy[1]), 64'd1);
        cyc();
        exe_valid = 1'b1; exe_idx = 5'd3; exe_data = 64'hDEADBEEF;
        #2;
        chk("t2_exe_ready", 64'(exe_ready), 64'd1);
        chk("t2_busy_wb", 64'(rd_busy[1]), BYP ? 64'd0 : 64'd1);
        chk("t2_data_wb", rd_data[1], BYP ? 64'hDEADBEEF : 64'd0);
        cyc();
        exe_valid = 1'b0;
        #2;
        chk("t2_busy_c", 64'(rd_busy[1]), 64'd0);
        chk("t2_data_c", rd_data[1], 64'hDEADBEEF);

        // 3: EXE and MEM collide, MEM first
        iss_valid = 1'b1; iss_dst = 5'd1;
        cyc();
        iss_dst = 5'd2;
        cyc();
        iss_valid = 1'b0;
        rd_idx[0] = 5'd1; rd_idx[1] = 5'd2;
        exe_valid = 1'b1; exe_idx = 5'd1; exe_data = 64'h1111;
        mem_valid = 1'b1; mem_idx = 5'd2; mem_data = 64'h2222;
        #2;
        chk("t3_mem_ready", 64'(mem_ready), 64'd1);
        chk("t3_exe_ready", 64'(exe_ready), 64'd0);
        chk("t3_busy", 64'(rd_busy[1:0]), BYP ? 64'd1 : 64'd3);
        cyc();
        mem_valid = 1'b0;
        #2;
        chk("t3_exe_ready2", 64'(exe_ready), 64'd1);
        chk("t3_r2", rd_data[1], 64'h2222);
        chk("t3_r2_busy", 64'(rd_busy[1]), 64'd0);
        chk("t3_r1_byp", rd_data[0], BYP ? 64'h1111 : 64'd0);
        chk("t3_r1_busy", 64'(rd_busy[0]), BYP ? 64'd0 : 64'd1);
        cyc();
        exe_valid = 1'b0;
        #2;
        chk("t3_r1", rd_data[0], 64'h1111);
        chk("t3_r1_busy2", 64'(rd_busy[0]), 64'd0);

        // 4: saturate r5 counter
        rd_idx[0] = 5'd5;
        iss_valid = 1'b1; iss_dst = 5'd5;
        for (int k = 0; k < 3; k++) begin
            #2;
            chk($sformatf("t4_ready_%0d", k), 64'(iss_ready), 64'd1);
            cyc();
        end
        #2;
        chk("t4_ready_full", 64'(iss_ready), 64'd0);
        cyc();
        iss_valid = 1'b0;
        #2;
        chk("t4_ready_hold", 64'(iss_ready), 64'd0);
        chk("t4_busy", 64'(rd_busy[0]), 64'd1);
        mem_valid = 1'b1; mem_idx = 5'd5; mem_data = 64'h55;
        cyc();
        mem_valid = 1'b0;
        #2;
        chk("t4_ready_back", 64'(iss_ready), 64'd1);
        chk("t4_data", rd_data[0], 64'h55);
        mem_valid = 1'b1; mem_data = 64'h56;
        cyc();
        #2;
        chk("t4_busy_1left", 64'(rd_busy[0]), BYP ? 64'd0 : 64'd1);
        cyc();
        mem_valid = 1'b0;
        #2;
        chk("t4_busy_drained", 64'(rd_busy[0]), 64'd0);
        chk("t4_data2", rd_data[0], 64'h56);

        // 5: issue and writeback to r7 in the same cycle
        rd_idx[0] = 5'd7;
        iss_valid = 1'b1; iss_dst = 5'd7;
        cyc();
        exe_valid = 1'b1; exe_idx = 5'd7; exe_data = 64'h77;
        #2;
        chk("t5_iss_ready", 64'(iss_ready), 64'd1);
        chk("t5_exe_ready", 64'(exe_ready), 64'd1);
        chk("t5_busy_same", 64'(rd_busy[0]), 64'd1);
        cyc();
        iss_valid = 1'b0; exe_valid = 1'b0;
        #2;
        chk("t5_busy", 64'(rd_busy[0]), 64'd1);
        chk("t5_data", rd_data[0], 64'h77);
        exe_valid = 1'b1; exe_data = 64'h78;
        cyc();
        exe_valid = 1'b0;
        #2;
        chk("t5_busy_drained", 64'(rd_busy[0]), 64'd0);
        chk("t5_data2", rd_data[0], 64'h78);

        // 6: flush with pending counts, writeback and issue in the flush cycle
        rd_idx[0] = 5'd2; rd_idx[1] = 5'd4; rd_idx[2] = 5'd3;
        iss_valid = 1'b1; iss_dst = 5'd2;
        cyc();
        iss_dst = 5'd4;
        cyc();
        iss_dst = 5'd3;
        cyc();
        iss_dst = 5'd6;
        #2;
        chk("t6_busy_pre", 64'(rd_busy), 64'd7);
        flush = 1'b1;
        mem_valid = 1'b1; mem_idx = 5'd3; mem_data = 64'hCAFE;
        #1;
        chk("t6_mem_ready", 64'(mem_ready), 64'd1);
        chk("t6_byp_data", rd_data[2], BYP ? 64'hCAFE : 64'hDEADBEEF);
        cyc();
        flush = 1'b0; mem_valid = 1'b0; iss_valid = 1'b0;
        #2;
        chk("t6_busy_post", 64'(rd_busy), 64'd0);
        chk("t6_r2", rd_data[0], 64'h2222);
        chk("t6_r4", rd_data[1], 64'd0);
        chk("t6_r3", rd_data[2], 64'hCAFE);
        rd_idx[0] = 5'd6;
        #2;
        chk("t6_r6_busy", 64'(rd_busy[0]), 64'd0);

        // 7: out-of-range index ignored, top register 16 usable
        iss_valid = 1'b1; iss_dst = 5'd20;
        rd_idx[0] = 5'd20; rd_idx[1] = 5'd16;
        #2;
        chk("t7_iss_ready_oor", 64'(iss_ready), 64'd1);
        cyc();
        iss_dst = 5'd16;
        #2;
        chk("t7_busy_oor", 64'(rd_busy[0]), 64'd0);
        cyc();
        iss_valid = 1'b0;
        mem_valid = 1'b1; mem_idx = 5'd20; mem_data = 64'hBAD;
        #2;
        chk("t7_mem_ready_oor", 64'(mem_ready), 64'd1);
        chk("t7_busy16", 64'(rd_busy[1]), 64'd1);
        cyc();
        mem_idx = 5'd16; mem_data = 64'h16;
        #2;
        chk("t7_data_oor", rd_data[0], 64'd0);
        cyc();
        mem_valid = 1'b0;
        #2;
        chk("t7_data16", rd_data[1], 64'h16);
        chk("t7_busy16_clr", 64'(rd_busy[1]), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
